// File: rtl/cp0_pkg.sv
// Shared coprocessor-0 definitions: register indices, field positions and exception codes.
// Also imported by the datapath and control so all three agree on the same encodings.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int IM_HI  = 15;
    localparam int IM_LO  = 10;
    localparam int EXL    = 1;
    localparam int IE     = 0;
    localparam int BD     = 31;
    localparam int IP_HI  = 15;
    localparam int IP_LO  = 10;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt/exception arbitration,
// mfc0/mtc0 access and the eret target.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_5005,
    parameter int          HWINT_W  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         A1,
    input  logic [4:0]         A2,
    input  logic [31:0]        DIn,
    input  logic               en,
    input  logic               EXLClr,
    input  logic [4:0]         ExcCodeIn,
    input  logic [31:0]        VPC,
    input  logic               BDIn,
    input  logic [HWINT_W-1:0] HWInt,
    output logic               Req,
    output logic [31:0]        DOut,
    output logic [31:0]        EPCOut
);

    logic [HWINT_W-1:0] im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic               bd_q, bd_d;
    logic [HWINT_W-1:0] ip_q, ip_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:2]        epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  sel_code;
    logic [31:0] victim_pc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;

    // Interrupts win over synchronous exceptions; EXL masks both.
    always_comb begin
        int_req  = ie_q & ~exl_q & (|(im_q & HWInt));
        exc_req  = ~exl_q & (ExcCodeIn != 5'd0);
        Req      = int_req | exc_req;
        sel_code = int_req ? 5'(EXC_INT) : ExcCodeIn;
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        victim_pc  = BDIn ? (VPC - 32'd4) : VPC;

        if (Req) begin
            exl_d      = 1'b1;
            exc_code_d = sel_code;
            bd_d       = BDIn;
            epc_d      = victim_pc[31:2];
        end else begin
            if (en && (A2 == REG_SR)) begin
                im_d  = DIn[IM_LO +: HWINT_W];
                exl_d = DIn[EXL];
                ie_d  = DIn[IE];
            end
            if (en && (A2 == REG_EPC)) begin
                epc_d = DIn[31:2];
            end
            // eret clears EXL even when the same cycle writes SR.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= 5'd0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        sr_val                      = '0;
        sr_val[IM_LO +: HWINT_W]    = im_q;
        sr_val[EXL]                 = exl_q;
        sr_val[IE]                  = ie_q;

        cause_val                   = '0;
        cause_val[BD]               = bd_q;
        cause_val[IP_LO +: HWINT_W] = ip_q;
        cause_val[EXC_HI:EXC_LO]    = exc_code_q;

        epc_val                     = {epc_q, 2'b00};
        EPCOut                      = epc_val;

        case (A1)
            REG_SR:    DOut = sr_val;
            REG_CAUSE: DOut = cause_val;
            REG_EPC:   DOut = epc_val;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: directed scenarios then random traffic, each cycle
// checked against a register-level reference model of coprocessor 0.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h0000_5005;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] DIn, VPC;
    logic        en, EXLClr, BDIn;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] DOut, EPCOut;

    cp0_unit #(.PRID_VAL(PRID), .HWINT_W(6)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .en(en),
        .EXLClr(EXLClr), .ExcCodeIn(ExcCodeIn), .VPC(VPC), .BDIn(BDIn),
        .HWInt(HWInt), .Req(Req), .DOut(DOut), .EPCOut(EPCOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        wen;
        logic        clr;
        logic [4:0]  code;
        logic [31:0] vpc;
        logic        bd;
        logic [5:0]  hw;
    } stim_t;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];

    // Architectural register images, kept as whole 32-bit words.
    logic [31:0] m_sr, m_cause, m_epc;

    int n_compared = 0;
    int n_mismatched = 0;
    int cycle_idx = 0;

    task automatic checkOutput(input exp_t e);
        n_compared++;
        if (Req !== e.req) begin
            n_mismatched++;
            $display("[TB] FAIL req cycle %0d: got %0b expected %0b", e.idx, Req, e.req);
        end
        n_compared++;
        if (DOut !== e.dout) begin
            n_mismatched++;
            $display("[TB] FAIL dout cycle %0d A1=%0d: got %h expected %h", e.idx, A1, DOut, e.dout);
        end
        n_compared++;
        if (EPCOut !== e.epc) begin
            n_mismatched++;
            $display("[TB] FAIL epcout cycle %0d: got %h expected %h", e.idx, EPCOut, e.epc);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end

    task automatic applyStimulus(input stim_t s);
        exp_t        e;
        logic        exl, ie, intr, exc, req;
        logic [4:0]  code;
        logic [31:0] pc;

        reset = s.rst; A1 = s.a1; A2 = s.a2; DIn = s.din; en = s.wen;
        EXLClr = s.clr; ExcCodeIn = s.code; VPC = s.vpc; BDIn = s.bd; HWInt = s.hw;

        exl  = m_sr[1];
        ie   = m_sr[0];
        intr = ie && !exl && ((m_sr[15:10] & s.hw) != 6'd0);
        exc  = !exl && (s.code != 5'd0);
        req  = intr || exc;

        e.idx  = cycle_idx;
        e.req  = req;
        e.epc  = m_epc;
        case (s.a1)
            5'd12:   e.dout = m_sr;
            5'd13:   e.dout = m_cause;
            5'd14:   e.dout = m_epc;
            5'd15:   e.dout = PRID;
            default: e.dout = 32'd0;
        endcase
        exp_q.push_back(e);

        if (s.rst) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, s.hw} << 10);
            if (req) begin
                code    = intr ? 5'd0 : s.code;
                pc      = s.bd ? s.vpc - 32'd4 : s.vpc;
                m_sr    = m_sr | 32'h2;
                m_cause = (m_cause & ~32'h8000_007C) | ({31'd0, s.bd} << 31) | ({27'd0, code} << 2);
                m_epc   = pc & ~32'h3;
            end else begin
                if (s.wen && s.a2 == 5'd12) m_sr = s.din & 32'h0000_FC03;
                if (s.wen && s.a2 == 5'd14) m_epc = s.din & ~32'h3;
                if (s.clr) m_sr = m_sr & ~32'h2;
            end
        end

        cycle_idx++;
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t idle(input logic [4:0] a1);
        stim_t s;
        s = '{rst: 1'b0, a1: a1, a2: 5'd0, din: 32'd0, wen: 1'b0, clr: 1'b0,
              code: 5'd0, vpc: 32'd0, bd: 1'b0, hw: 6'd0};
        return s;
    endfunction

    function automatic logic [4:0] pick_code();
        logic [4:0] codes [5];
        codes = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
        return ($urandom_range(0, 2) == 0) ? codes[$urandom_range(1, 4)] : 5'd0;
    endfunction

    initial begin
        stim_t s;
        int    wait_cycles;

        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; en = 1'b0; EXLClr = 1'b0;
        ExcCodeIn = 5'd0; VPC = 32'd0; BDIn = 1'b0; HWInt = 6'd0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        @(posedge clk);
        #1;

        // SR write then readback.
        s = idle(5'd12); s.wen = 1'b1; s.a2 = 5'd12; s.din = 32'h0000_FC01; applyStimulus(s);
        applyStimulus(idle(5'd12));
        // Interrupt on line 2 (IP bit 12).
        s = idle(5'd13); s.hw = 6'b000100; s.vpc = 32'h0000_3010; applyStimulus(s);
        s = idle(5'd13); s.hw = 6'b000100; s.code = 5'd4; applyStimulus(s);
        s = idle(5'd12); s.clr = 1'b1; applyStimulus(s);
        // Overflow in a delay slot.
        s = idle(5'd14); s.code = 5'd12; s.bd = 1'b1; s.vpc = 32'h0000_3020; applyStimulus(s);
        s = idle(5'd13); s.clr = 1'b1; applyStimulus(s);
        // Interrupt and AdEL together: interrupt code wins.
        s = idle(5'd13); s.hw = 6'b000100; s.code = 5'd4; s.vpc = 32'h0000_3030; applyStimulus(s);
        s = idle(5'd13); s.clr = 1'b1; applyStimulus(s);
        // Exception drops a same-cycle EPC write.
        s = idle(5'd14); s.code = 5'd10; s.wen = 1'b1; s.a2 = 5'd14; s.din = 32'h1234_5678;
        s.vpc = 32'h0000_4000; applyStimulus(s);
        s = idle(5'd14); s.clr = 1'b1; applyStimulus(s);
        // mtc0 to EPC, Cause and PRId.
        s = idle(5'd14); s.wen = 1'b1; s.a2 = 5'd14; s.din = 32'h1234_5677; applyStimulus(s);
        s = idle(5'd13); s.wen = 1'b1; s.a2 = 5'd13; s.din = 32'hFFFF_FFFF; applyStimulus(s);
        s = idle(5'd15); s.wen = 1'b1; s.a2 = 5'd15; s.din = 32'hFFFF_FFFF; applyStimulus(s);
        // Wrap-around of VPC-4.
        s = idle(5'd14); s.code = 5'd5; s.bd = 1'b1; s.vpc = 32'd0; applyStimulus(s);
        s = idle(5'd12); s.code = 5'd4; s.hw = 6'b111111; applyStimulus(s);
        // EXLClr together with an SR write.
        s = idle(5'd12); s.clr = 1'b1; s.wen = 1'b1; s.a2 = 5'd12; s.din = 32'h0000_0C03; applyStimulus(s);
        // Reset dominates a pending exception and write.
        s = idle(5'd14); s.rst = 1'b1; s.code = 5'd4; s.wen = 1'b1; s.a2 = 5'd14; s.din = 32'hABCD_0000;
        applyStimulus(s);
        for (int r = 12; r <= 16; r++) applyStimulus(idle(5'(r)));

        for (int i = 0; i < 400; i++) begin
            s.rst  = ($urandom_range(0, 49) == 0);
            s.a1   = 5'($urandom_range(10, 16));
            s.a2   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            s.din  = $urandom;
            s.wen  = ($urandom_range(0, 2) == 0);
            s.clr  = ($urandom_range(0, 3) == 0);
            s.code = pick_code();
            s.vpc  = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            s.bd   = 1'($urandom);
            s.hw   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            applyStimulus(s);
        end

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
